// File: rtl/datapath.sv
// Windowed seizure-detection feature extractor: line length, nonlinear energy, power and
// three biquad band powers per window, plus a 2-of-4 stimulation vote.
module datapath #(
    parameter int WIN_LOG2 = 8,
    parameter int LL_TH    = 50000,
    parameter int NE_TH    = 1000000,
    parameter int PS_TH    = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] ll_test,
    output logic [31:0] ne_test,
    output logic [31:0] ps_test,
    output logic [31:0] theta_test,
    output logic [31:0] alpha_test,
    output logic [31:0] beta_test,
    output logic        stimulation
);

    localparam int ACC_W = 47 + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CNT_LAST = {WIN_LOG2{1'b1}};
    localparam logic [31:0]        LL_TH_U  = 32'(LL_TH);
    localparam logic signed [31:0] NE_TH_S  = 32'(NE_TH);
    localparam logic [31:0]        PS_TH_U  = 32'(PS_TH);

    // Band index 0 = theta, 1 = alpha, 2 = beta; Q14 coefficients.
    function automatic logic signed [15:0] coef_b0(input logic [1:0] band);
        case (band)
            2'd0:    coef_b0 = 16'sd764;
            2'd1:    coef_b0 = 16'sd937;
            2'd2:    coef_b0 = 16'sd2720;
            default: coef_b0 = 16'sd0;
        endcase
    endfunction

    function automatic logic signed [15:0] coef_a1(input logic [1:0] band);
        case (band)
            2'd0:    coef_a1 = -16'sd30902;
            2'd1:    coef_a1 = -16'sd29873;
            2'd2:    coef_a1 = -16'sd23610;
            default: coef_a1 = 16'sd0;
        endcase
    endfunction

    function automatic logic signed [15:0] coef_a2(input logic [1:0] band);
        case (band)
            2'd0:    coef_a2 = 16'sd14856;
            2'd1:    coef_a2 = 16'sd14509;
            2'd2:    coef_a2 = 16'sd10944;
            default: coef_a2 = 16'sd0;
        endcase
    endfunction

    function automatic logic signed [23:0] biquad(
        input logic signed [16:0] dx,
        input logic signed [23:0] y1,
        input logic signed [23:0] y2,
        input logic signed [15:0] b0,
        input logic signed [15:0] a1,
        input logic signed [15:0] a2
    );
        logic signed [47:0] acc;
        logic signed [47:0] q;
        acc = 48'(b0) * 48'(dx) - 48'(a1) * 48'(y1) - 48'(a2) * 48'(y2);
        q   = acc >>> 14;
        if (q > 48'sd8388607) begin
            biquad = 24'sh7F_FFFF;
        end else if (q < -48'sd8388608) begin
            biquad = 24'sh80_0000;
        end else begin
            biquad = 24'(q);
        end
    endfunction

    function automatic logic [46:0] square24(input logic signed [23:0] y);
        logic signed [47:0] p;
        p        = 48'(y) * 48'(y);
        square24 = 47'(p);
    endfunction

    function automatic logic [31:0] sat_s32(input logic signed [40:0] v);
        if (v > 41'sd2147483647) begin
            sat_s32 = 32'h7FFF_FFFF;
        end else if (v < -41'sd2147483648) begin
            sat_s32 = 32'h8000_0000;
        end else begin
            sat_s32 = 32'(v);
        end
    endfunction

    logic signed [15:0] x_s;
    logic               din_hi_unused_s;
    logic signed [15:0] xm1_r, xm2_r;
    logic [WIN_LOG2-1:0] cnt_r;
    logic               last_s;
    logic signed [16:0] dx1_s, dx2_s;
    logic [16:0]        ll_term_s;
    logic signed [31:0] sq_m1_s, cross_s, sq_x_s;
    logic signed [40:0] ne_term_s;
    logic [39:0]        ps_term_s;
    logic signed [23:0] y_s   [3];
    logic [46:0]        ysq_s [3];
    logic signed [23:0] y1_r  [3];
    logic signed [23:0] y2_r  [3];

    logic [24:0]        ll_acc_r, ll_fin_r;
    logic signed [40:0] ne_acc_r, ne_fin_r;
    logic [39:0]        ps_acc_r, ps_fin_r;
    logic [ACC_W-1:0]   band_acc_r [3];
    logic [ACC_W-1:0]   band_fin_r [3];
    logic               v1_r, v2_r;

    logic signed [40:0] ne_sh_s;
    logic [ACC_W-1:0]   band_sh_s   [3];
    logic [31:0]        ll_feat_s, ne_feat_s, ps_feat_s;
    logic [31:0]        band_feat_s [3];
    logic [31:0]        ll_feat_r, ne_feat_r, ps_feat_r;
    logic [31:0]        band_feat_r [3];
    logic [32:0]        ta_sum_s;
    logic [2:0]         votes_s;
    logic               stim_s;

    assign x_s             = din[15:0];
    assign din_hi_unused_s = ^din[31:16];
    assign last_s          = (cnt_r == CNT_LAST);
    assign dx1_s           = 17'(x_s) - 17'(xm1_r);
    assign dx2_s           = 17'(x_s) - 17'(xm2_r);
    assign ll_term_s       = dx1_s[16] ? 17'(-dx1_s) : 17'(dx1_s);
    assign sq_m1_s         = xm1_r * xm1_r;
    assign cross_s         = x_s * xm2_r;
    assign sq_x_s          = x_s * x_s;
    assign ne_term_s       = 41'(sq_m1_s) - 41'(cross_s);
    assign ps_term_s       = 40'(sq_x_s);

    // Per-sample band filter outputs and their squares.
    always_comb begin
        for (int b = 0; b < 3; b++) begin
            y_s[b]   = biquad(dx2_s, y1_r[b], y2_r[b],
                              coef_b0(2'(b)), coef_a1(2'(b)), coef_a2(2'(b)));
            ysq_s[b] = square24(y_s[b]);
        end
    end

    // Sample acceptance: history, filter state, window count and accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xm1_r    <= '0;
            xm2_r    <= '0;
            cnt_r    <= '0;
            ll_acc_r <= '0;
            ne_acc_r <= '0;
            ps_acc_r <= '0;
            ll_fin_r <= '0;
            ne_fin_r <= '0;
            ps_fin_r <= '0;
            v1_r     <= 1'b0;
            for (int b = 0; b < 3; b++) begin
                y1_r[b]       <= '0;
                y2_r[b]       <= '0;
                band_acc_r[b] <= '0;
                band_fin_r[b] <= '0;
            end
        end else begin
            v1_r <= en && last_s;
            if (en) begin
                xm1_r <= x_s;
                xm2_r <= xm1_r;
                cnt_r <= cnt_r + WIN_LOG2'(1);
                for (int b = 0; b < 3; b++) begin
                    y2_r[b] <= y1_r[b];
                    y1_r[b] <= y_s[b];
                end
                // The closing sample goes straight into the final sums; the next window starts clean.
                if (last_s) begin
                    ll_fin_r <= ll_acc_r + 25'(ll_term_s);
                    ne_fin_r <= ne_acc_r + ne_term_s;
                    ps_fin_r <= ps_acc_r + ps_term_s;
                    ll_acc_r <= '0;
                    ne_acc_r <= '0;
                    ps_acc_r <= '0;
                    for (int b = 0; b < 3; b++) begin
                        band_fin_r[b] <= band_acc_r[b] + ACC_W'(ysq_s[b]);
                        band_acc_r[b] <= '0;
                    end
                end else begin
                    ll_acc_r <= ll_acc_r + 25'(ll_term_s);
                    ne_acc_r <= ne_acc_r + ne_term_s;
                    ps_acc_r <= ps_acc_r + ps_term_s;
                    for (int b = 0; b < 3; b++) begin
                        band_acc_r[b] <= band_acc_r[b] + ACC_W'(ysq_s[b]);
                    end
                end
            end
        end
    end

    // Scale and saturate the closed window sums into 32-bit features.
    always_comb begin
        ne_sh_s   = ne_fin_r >>> WIN_LOG2;
        ll_feat_s = {7'd0, ll_fin_r};
        ne_feat_s = sat_s32(ne_sh_s);
        ps_feat_s = 32'(ps_fin_r >> WIN_LOG2);
        for (int b = 0; b < 3; b++) begin
            band_sh_s[b]   = band_fin_r[b] >> WIN_LOG2;
            band_feat_s[b] = (|band_sh_s[b][ACC_W-1:32]) ? 32'hFFFF_FFFF : band_sh_s[b][31:0];
        end
    end

    // Second pipeline stage: registered features.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ll_feat_r <= '0;
            ne_feat_r <= '0;
            ps_feat_r <= '0;
            v2_r      <= 1'b0;
            for (int b = 0; b < 3; b++) begin
                band_feat_r[b] <= '0;
            end
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                ll_feat_r <= ll_feat_s;
                ne_feat_r <= ne_feat_s;
                ps_feat_r <= ps_feat_s;
                for (int b = 0; b < 3; b++) begin
                    band_feat_r[b] <= band_feat_s[b];
                end
            end
        end
    end

    // Stimulation vote: at least two of the four feature tests must fire.
    always_comb begin
        ta_sum_s = {1'b0, band_feat_r[0]} + {1'b0, band_feat_r[1]};
        votes_s  = {2'b00, (ll_feat_r > LL_TH_U)}
                 + {2'b00, ($signed(ne_feat_r) > NE_TH_S)}
                 + {2'b00, (ps_feat_r > PS_TH_U)}
                 + {2'b00, (ta_sum_s > {1'b0, band_feat_r[2]})};
        stim_s   = (votes_s >= 3'd2);
    end

    // Output stage: features and vote publish together, then hold until the next window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ll_test     <= '0;
            ne_test     <= '0;
            ps_test     <= '0;
            theta_test  <= '0;
            alpha_test  <= '0;
            beta_test   <= '0;
            stimulation <= 1'b0;
        end else if (v2_r) begin
            ll_test     <= ll_feat_r;
            ne_test     <= ne_feat_r;
            ps_test     <= ps_feat_r;
            theta_test  <= band_feat_r[0];
            alpha_test  <= band_feat_r[1];
            beta_test   <= band_feat_r[2];
            stimulation <= stim_s;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed feature vectors plus randomized stimulus
// checked every cycle against a window-level arithmetic reference model.
module tb_datapath;

    localparam int WIN = 256;

    logic        clk, rst, en;
    logic [31:0] din;
    logic [31:0] ll_test, ne_test, ps_test, theta_test, alpha_test, beta_test;
    logic        stimulation;

    datapath dut (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .ll_test(ll_test), .ne_test(ne_test), .ps_test(ps_test),
        .theta_test(theta_test), .alpha_test(alpha_test), .beta_test(beta_test),
        .stimulation(stimulation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        logic [31:0] ll, ne, ps, th, al, be;
        logic        st;
        longint      due;
    } res_t;

    longint B0 [3] = '{764, 937, 2720};
    longint A1 [3] = '{-30902, -29873, -23610};
    longint A2 [3] = '{14856, 14509, 10944};

    longint xm1, xm2, ll_sum, ne_sum, ps_sum, edge_n;
    longint y1 [3];
    longint y2 [3];
    longint band_sum [3];
    int     cnt;
    res_t   pend_q [$];
    logic [31:0] e_ll, e_ne, e_ps, e_th, e_al, e_be;
    logic        e_st;

    task automatic model_reset();
        xm1 = 0; xm2 = 0; ll_sum = 0; ne_sum = 0; ps_sum = 0; cnt = 0;
        for (int b = 0; b < 3; b++) begin
            y1[b] = 0; y2[b] = 0; band_sum[b] = 0;
        end
        pend_q.delete();
        e_ll = 32'd0; e_ne = 32'd0; e_ps = 32'd0;
        e_th = 32'd0; e_al = 32'd0; e_be = 32'd0; e_st = 1'b0;
    endtask

    task automatic model_accept(input logic [31:0] d);
        shortint s;
        longint  x, v, nv, pv;
        longint  bres [3];
        int      votes;
        res_t    r;
        s = d[15:0];
        x = s;
        ll_sum += (x >= xm1) ? (x - xm1) : (xm1 - x);
        ne_sum += xm1 * xm1 - x * xm2;
        ps_sum += x * x;
        for (int b = 0; b < 3; b++) begin
            v = (B0[b] * (x - xm2) - A1[b] * y1[b] - A2[b] * y2[b]) >>> 14;
            if (v > 64'sd8388607) v = 64'sd8388607;
            else if (v < -64'sd8388608) v = -64'sd8388608;
            band_sum[b] += v * v;
            y2[b] = y1[b];
            y1[b] = v;
        end
        xm2 = xm1;
        xm1 = x;
        cnt++;
        if (cnt == WIN) begin
            nv = ne_sum >>> 8;
            if (nv > 64'sd2147483647) nv = 64'sd2147483647;
            else if (nv < -64'sd2147483648) nv = -64'sd2147483648;
            pv = ps_sum >> 8;
            for (int b = 0; b < 3; b++) begin
                bres[b] = band_sum[b] >> 8;
                if (bres[b] > 64'sd4294967295) bres[b] = 64'sd4294967295;
            end
            votes = 0;
            if (ll_sum > 64'sd50000) votes++;
            if (nv > 64'sd1000000) votes++;
            if (pv > 64'sd100000) votes++;
            if (bres[0] + bres[1] > bres[2]) votes++;
            r.ll = 32'(ll_sum); r.ne = 32'(nv); r.ps = 32'(pv);
            r.th = 32'(bres[0]); r.al = 32'(bres[1]); r.be = 32'(bres[2]);
            r.st = (votes >= 2);
            r.due = edge_n + 2;
            pend_q.push_back(r);
            ll_sum = 0; ne_sum = 0; ps_sum = 0; cnt = 0;
            for (int b = 0; b < 3; b++) band_sum[b] = 0;
        end
    endtask

    task automatic model_edge(input logic acc, input logic [31:0] d);
        edge_n++;
        while (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
            e_ll = pend_q[0].ll; e_ne = pend_q[0].ne; e_ps = pend_q[0].ps;
            e_th = pend_q[0].th; e_al = pend_q[0].al; e_be = pend_q[0].be;
            e_st = pend_q[0].st;
            void'(pend_q.pop_front());
        end
        if (acc) model_accept(d);
    endtask

    task automatic check_outputs();
        chk("ll",    ll_test,    e_ll);
        chk("ne",    ne_test,    e_ne);
        chk("ps",    ps_test,    e_ps);
        chk("theta", theta_test, e_th);
        chk("alpha", alpha_test, e_al);
        chk("beta",  beta_test,  e_be);
        chk("stim",  {31'd0, stimulation}, {31'd0, e_st});
    endtask

    // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
    task automatic step(input logic e, input logic [31:0] d);
        en  = e;
        din = d;
        @(posedge clk);
        model_edge(e && !rst, d);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        for (int i = 0; i < n; i++) step(1'($urandom), $urandom);
        rst = 1'b0;
    endtask

    task automatic chk_feat(input string tag, input logic [31:0] ll, input logic [31:0] ne,
                            input logic [31:0] ps, input logic st);
        chk({tag, "_ll"},   ll_test, ll);
        chk({tag, "_ne"},   ne_test, ne);
        chk({tag, "_ps"},   ps_test, ps);
        chk({tag, "_stim"}, {31'd0, stimulation}, {31'd0, st});
    endtask

    function automatic logic [31:0] alt(input int i);
        alt = (i % 2 == 0) ? 32'd1000 : 32'hFFFF_FC18;
    endfunction

    initial begin
        logic [31:0] d;
        int          mode;
        edge_n = 0;
        rst = 1'b1; en = 1'b0; din = 32'd0;
        model_reset();
        @(negedge clk);

        // Long power-on reset; outputs stay zero through it and until a window closes.
        do_reset(30);
        chk("rst_zero_ll", ll_test, 32'd0);

        // Constant 100, including the exact update latency.
        for (int i = 0; i < WIN; i++) step(1'b1, 32'd100);
        step(1'b1, 32'd100);
        chk("const_early_ll", ll_test, 32'd0);
        step(1'b1, 32'd100);
        chk_feat("const", 32'd100, 32'd39, 32'd10000, 1'b0);

        // Alternating +/-1000.
        do_reset(2);
        for (int i = 0; i < WIN; i++) step(1'b1, alt(i));
        step(1'b1, 32'd0);
        step(1'b1, 32'd0);
        chk_feat("alt", 32'd511000, 32'd3906, 32'd1000000, 1'b1);

        // en toggling: latency counts from the last accepted sample.
        do_reset(2);
        for (int i = 0; i < 2 * WIN - 1; i++) step(i % 2 == 0, 32'd100);
        step(1'b0, 32'd100);
        chk("tog_early_ll", ll_test, 32'd0);
        step(1'b1, 32'd100);
        chk_feat("tog", 32'd100, 32'd39, 32'd10000, 1'b0);

        // Partial window discarded by a reset pulse.
        do_reset(2);
        for (int i = 0; i < 100; i++) step(1'b1, alt(i));
        do_reset(1);
        chk("pulse_zero_ll", ll_test, 32'd0);
        for (int i = 0; i < WIN + 2; i++) step(1'b1, 32'd100);
        chk_feat("pulse", 32'd100, 32'd39, 32'd10000, 1'b0);

        // Upper din bits are ignored.
        do_reset(2);
        for (int i = 0; i < WIN + 2; i++) step(1'b1, 32'h0001_0064);
        chk_feat("hibits", 32'd100, 32'd39, 32'd10000, 1'b0);

        // Randomized stimulus against the model, with a mid-run reset.
        for (int c = 0; c < 6; c++) begin
            mode = c % 3;
            for (int k = 0; k < 260; k++) begin
                if (c == 3 && k == 100) do_reset(2);
                case (mode)
                    0:       d = $urandom;
                    1:       d = {16'($urandom), 16'($urandom_range(0, 400) - 200)};
                    default: d = ((k / 4) % 2 == 1) ? 32'hFFFF_B1E0 : 32'd20000;
                endcase
                step($urandom_range(0, 3) != 0, d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL expose parameter WIN_LOG2, default 8, window length 2^WIN_LOG2 accepted samples.
REQ-002 SHALL expose parameter LL_TH, default 50000, line-length threshold.
REQ-003 SHALL expose parameter NE_TH, default 1000000, nonlinear-energy threshold.
REQ-004 SHALL expose parameter PS_TH, default 100000, power threshold.
REQ-005 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample valid.
- din  in  32  signed sample; only din[15:0] is used, as signed 16-bit x.
- ll_test  out  32  line length.
- ne_test  out  32  nonlinear energy.
- ps_test  out  32  power.
- theta_test  out  32  theta band power.
- alpha_test  out  32  alpha band power.
- beta_test  out  32  beta band power.
- stimulation  out  1  seizure/stimulate flag.

Function
REQ-006 SHALL accept x on every rising edge with en=1 and rst=0; en=0 holds all history, filter state and window count.
REQ-007 SHALL keep sample history x[n-1], x[n-2] across window boundaries; history is zero after reset.
REQ-008 LL window sum SHALL be Σ|x[n]-x[n-1]| (25-bit unsigned); ll_test = sum, zero-extended.
REQ-009 NE SHALL be Σ(x[n-1]^2 - x[n]*x[n-2]) (signed 41-bit); ne_test = sum >>> WIN_LOG2, saturated to signed 32-bit.
REQ-010 PS SHALL be Σx[n]^2 (40-bit); ps_test = sum >> WIN_LOG2.
REQ-011 Each band SHALL be a biquad: y[n] = (b0*(x[n]-x[n-2]) - a1*y[n-1] - a2*y[n-2]) >>> 14, with y saturated to signed 24-bit.
- Coefficients are Q14 (b0, a1, a2):
  - theta: 764, -30902, 14856.
  - alpha: 937, -29873, 14509.
  - beta: 2720, -23610, 10944.
- Filter state persists across windows and is zero after reset.
REQ-012 Band output SHALL be (Σy^2) >> WIN_LOG2, saturated to unsigned 32-bit.
REQ-013 Window counter SHALL count accepted samples modulo 2^WIN_LOG2. On the last sample of a window, all six results SHALL latch to the outputs, and all accumulators SHALL clear so the next sample starts a fresh window.
REQ-014 Outputs SHALL update on the 2nd rising edge after the edge that accepted the last window sample. This 2-cycle latency is fixed, independent of en after that edge.
REQ-015 Outputs SHALL hold their values between updates.
REQ-016 stimulation SHALL update on the same edge as the features: 1 iff at least 2 of these 4 conditions hold:
- ll > LL_TH
- ne (signed) > NE_TH
- ps > PS_TH
- theta+alpha (33-bit) > beta
REQ-017 All arithmetic SHALL be bit-exact as specified: floor shifts, no rounding.

Reset
REQ-018 rst=1 SHALL immediately clear all outputs, accumulators, window counter, history, filter state and pipeline valids to 0.
REQ-019 Reset asserted mid-window SHALL discard the partial window; the first accepted sample after release is window sample 0.
REQ-020 With rst=1, en and din SHALL be ignored.

Verification
REQ-021 Reset: assert rst for 300 ns. All seven outputs read 0 during reset and until the first window completes.
REQ-022 Constant din=100, 256 samples from reset, en=1:
- ll_test=100, ps_test=10000, ne_test=39, stimulation=0.
- Outputs appear 2 cycles after the 256th sample.
REQ-023 Alternating +1000/-1000 (starting +1000), 256 samples from reset:
- ll_test=511000, ps_test=1000000, ne_test=3906, stimulation=1.
REQ-024 Repeat REQ-022 with en toggling 1/0 every cycle: identical output values; update occurs 2 cycles after the 256th accepted sample.
REQ-025 Run 100 samples of REQ-023, pulse rst, then run REQ-022 stimulus: outputs are 0 after the pulse, then exactly the REQ-022 values.
REQ-026 din=0x0001_0064 constant: results identical to REQ-022, since upper bits are ignored.
